// File: rtl/simple_cpu_hs.sv
// Multi-cycle memory-to-memory CPU with a req/ack memory port for variable-latency RAM.
// Instruction word {op[2:0], imm, A[13:0], B[13:0]}; halts on a branch to itself.
module simple_cpu_hs #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          halted,
    output logic [31:0]   retired,
    output logic [2:0]    state_dbg
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_RD_A   = 3'd2;
    localparam logic [2:0] S_RD_B   = 3'd3;
    localparam logic [2:0] S_RD_IND = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_LT   = 3'b011;
    localparam logic [2:0] OP_CP   = 3'b100;
    localparam logic [2:0] OP_CPI  = 3'b101;
    localparam logic [2:0] OP_BZJ  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [DW-1:0] DW_V = DW'(DW);

    // Handshake: a request (mem_req with addr/we/wdata) is held unchanged until the
    // cycle mem_ack is high; that rising edge completes it. mem_ack without mem_req is ignored.

    logic [2:0]    state;
    logic [AW-1:0] pc;
    logic [31:0]   iw;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;

    logic [2:0]    op;
    logic          imm;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] bi;
    logic [DW-1:0] opb;
    logic [DW-1:0] result;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] pc_inc;
    logic [DW-1:0] br_sum;
    logic [AW-1:0] br_target;
    logic          is_bzj;

    assign op        = iw[31:29];
    assign imm       = iw[28];
    assign a_addr    = iw[14 +: AW];
    assign b_addr    = iw[0 +: AW];
    assign bi        = DW'(iw[13:0]);
    assign opb       = imm ? bi : rb;
    assign is_bzj    = (op == OP_BZJ);
    assign pc_inc    = pc + AW'(1);
    assign wr_addr   = (op == OP_CPI && imm) ? ra[AW-1:0] : a_addr;
    assign halted    = (state == S_HALT);
    assign state_dbg = state;

    // Branch target is taken straight from the read data on the resolving ack.
    assign br_sum = mem_rdata + bi;
    always_comb begin
        br_target = pc_inc;
        if (state == S_RD_A) begin
            br_target = br_sum[AW-1:0];
        end else if (mem_rdata == '0) begin
            br_target = ra[AW-1:0];
        end
    end

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = ra + opb;
            OP_NAND: result = ~(ra & opb);
            OP_SRL: begin
                if (opb < DW_V) result = ra >> opb;
                else            result = ra << (opb - DW_V);
            end
            OP_LT:   result = {{(DW-1){1'b0}}, (ra < opb)};
            OP_MUL:  result = ra * opb;
            OP_CP:   result = opb;
            OP_CPI:  result = rb;
            default: result = '0;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                S_FETCH:  begin mem_req = 1'b1; mem_addr = pc;          end
                S_RD_A:   begin mem_req = 1'b1; mem_addr = a_addr;      end
                S_RD_B:   begin mem_req = 1'b1; mem_addr = b_addr;      end
                S_RD_IND: begin mem_req = 1'b1; mem_addr = rb[AW-1:0];  end
                S_WRITE: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = result;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= '0;
            iw      <= '0;
            ra      <= '0;
            rb      <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: if (mem_ack) begin
                    // Builds with DW < 32 see only the low DW bits of the word.
                    iw    <= 32'(mem_rdata);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (op == OP_CP)             state <= imm ? S_WRITE : S_RD_B;
                    else if (op == OP_CPI && !imm) state <= S_RD_B;
                    else                         state <= S_RD_A;
                end
                S_RD_A: if (mem_ack) begin
                    ra <= mem_rdata;
                    if (is_bzj && imm) begin
                        retired <= retired + 32'd1;
                        if (br_target == pc) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= br_target;
                            state <= S_FETCH;
                        end
                    end else if (imm && op != OP_CPI && !is_bzj) begin
                        state <= S_WRITE;
                    end else begin
                        state <= S_RD_B;
                    end
                end
                S_RD_B: if (mem_ack) begin
                    rb <= mem_rdata;
                    if (is_bzj) begin
                        retired <= retired + 32'd1;
                        if (br_target == pc) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= br_target;
                            state <= S_FETCH;
                        end
                    end else if (op == OP_CPI && !imm) begin
                        state <= S_RD_IND;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_RD_IND: if (mem_ack) begin
                    rb    <= mem_rdata;
                    state <= S_WRITE;
                end
                S_WRITE: if (mem_ack) begin
                    pc      <= pc_inc;
                    retired <= retired + 32'd1;
                    state   <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_cpu_hs.sv
// Bench for simple_cpu_hs: RAM model with random ack latency, write-stream scoreboard,
// halt/retire checks, plus a narrow build exercising reset during a pending read.
module tb_simple_cpu_hs;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (DW=32, AW=10) ----------------
    logic        mem_req, mem_we, mem_ack, halted;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, retired;
    logic [2:0]  state_dbg;

    simple_cpu_hs #(.DW(32), .AW(10)) u_dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .halted(halted), .retired(retired), .state_dbg(state_dbg)
    );

    // ---------------- narrow DUT (DW=16, AW=8) ----------------
    logic        s_rst = 1'b1;
    logic        s_req, s_we, s_halted;
    logic        s_ack = 1'b0;
    logic [7:0]  s_addr;
    logic [15:0] s_wdata;
    logic [15:0] s_rdata = '0;
    logic [31:0] s_retired;
    logic [2:0]  s_state;

    simple_cpu_hs #(.DW(16), .AW(8)) u_small (
        .clk(clk), .rst(s_rst),
        .mem_req(s_req), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .mem_ack(s_ack), .mem_rdata(s_rdata),
        .halted(s_halted), .retired(s_retired), .state_dbg(s_state)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [41:0] exp_q[$];      // {addr, data} of each expected write, in order
    logic [31:0] mem [1024];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [2:0] op, input logic imm, input int a, input int b);
        return {op, imm, a[13:0], b[13:0]};
    endfunction

    // A branch-immediate on the always-zero cell 1000 targeting its own pc.
    function automatic logic [31:0] halt_at(input int p);
        return ins(3'b110, 1'b1, 1000, p);
    endfunction

    task automatic push_wr(input int a, input logic [31:0] d);
        exp_q.push_back({a[9:0], d});
    endtask

    // ---------------- RAM responder ----------------
    int          delay_max = 0;
    int          wait_cnt = 0;
    int          cur_delay = 0;
    int          stab_err = 0;
    int          req_after_halt = 0;
    logic        p_pend = 1'b0;
    logic        p_we;
    logic [9:0]  p_addr;
    logic [31:0] p_wdata;

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if (halted && mem_req) req_after_halt++;
        if (!rst && mem_req) begin
            if (p_pend && (mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata)) stab_err++;
            if (!mem_we && mem_wdata !== 32'd0) stab_err++;
            if (wait_cnt >= cur_delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    if (exp_q.size() == 0) check_val("wr_unexpected", 64'(exp_q.size()), 64'd1);
                    else check_val("wr_stream", 64'({mem_addr, mem_wdata}), 64'(exp_q.pop_front()));
                end else begin
                    mem_rdata = mem[mem_addr];
                end
                wait_cnt  = 0;
                cur_delay = $urandom_range(delay_max, 0);
                p_pend    = 1'b0;
            end else begin
                wait_cnt++;
                p_pend  = 1'b1;
                p_we    = mem_we;
                p_addr  = mem_addr;
                p_wdata = mem_wdata;
            end
        end else begin
            if (p_pend && !rst) stab_err++;
            p_pend = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic begin_test(input int dmax);
        rst = 1'b1;
        delay_max = dmax;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        exp_q.delete();
        req_after_halt = 0;
    endtask

    task automatic release_rst();
        wait_cnt  = 0;
        cur_delay = $urandom_range(delay_max, 0);
        rst = 1'b0;
    endtask

    task automatic run_halt(input string tag, input int bound, input int exp_ret);
        int n = 0;
        while (!halted && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, "_halted"}, 64'(halted), 64'd1);
        check_val({tag, "_retired"}, 64'(retired), 64'(exp_ret));
        check_val({tag, "_wr_left"}, 64'(exp_q.size()), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check_val({tag, "_req_after_halt"}, 64'(req_after_halt), 64'd0);
        check_val({tag, "_retired_hold"}, 64'(retired), 64'(exp_ret));
    endtask

    task automatic load_add_prog();
        mem[0]  = ins(3'b000, 1'b0, 69, 70);
        mem[1]  = halt_at(1);
        mem[69] = 32'd1;
        mem[70] = 32'd1000;
        push_wr(69, 32'd1001);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;

        // ADD with zero-wait RAM: five clocks to the first retirement
        begin_test(0);
        check_val("reset_req", 64'(mem_req), 64'd0);
        check_val("reset_retired", 64'(retired), 64'd0);
        check_val("reset_halted", 64'(halted), 64'd0);
        load_add_prog();
        release_rst();
        n = 0;
        while (retired != 32'd1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("add_cycles", 64'(n), 64'd5);
        run_halt("add0", 200, 2);
        check_val("add0_mem69", 64'(mem[69]), 64'd1001);

        // Same program under random ack latency
        begin_test(7);
        load_add_prog();
        release_rst();
        run_halt("add_rand", 2000, 2);
        check_val("add_rand_mem69", 64'(mem[69]), 64'd1001);
        check_val("add_rand_mem70", 64'(mem[70]), 64'd1000);

        // ALU and copy coverage
        begin_test(3);
        mem[0]  = ins(3'b001, 1'b0, 310, 311);
        mem[1]  = ins(3'b011, 1'b0, 312, 313);
        mem[2]  = ins(3'b011, 1'b1, 314, 7);
        mem[3]  = ins(3'b111, 1'b0, 316, 317);
        mem[4]  = ins(3'b000, 1'b1, 318, 2);
        mem[5]  = ins(3'b100, 1'b1, 320, 14'h3abc);
        mem[6]  = ins(3'b100, 1'b0, 321, 311);
        mem[7]  = ins(3'b001, 1'b1, 322, 14'h0ff);
        mem[8]  = ins(3'b010, 1'b0, 323, 324);
        mem[9]  = ins(3'b111, 1'b1, 325, 3);
        mem[10] = halt_at(10);
        mem[310] = 32'h1234_5678; mem[311] = 32'h0000_ffff;
        mem[312] = 32'd7;         mem[313] = 32'd9;
        mem[314] = 32'd9;
        mem[316] = 32'h0001_0001; mem[317] = 32'h0001_0001;
        mem[318] = 32'hffff_ffff;
        mem[322] = 32'h0000_00f0;
        mem[323] = 32'h8000_0000; mem[324] = 32'd4;
        mem[325] = 32'd5;
        push_wr(310, ~(32'h1234_5678 & 32'h0000_ffff));
        push_wr(312, 32'd1);
        push_wr(314, 32'd0);
        push_wr(316, 32'h0002_0001);
        push_wr(318, 32'd1);
        push_wr(320, 32'h0000_3abc);
        push_wr(321, 32'h0000_ffff);
        push_wr(322, 32'hffff_ff0f);
        push_wr(323, 32'h0800_0000);
        push_wr(325, 32'd15);
        release_rst();
        run_halt("alu", 4000, 11);

        // Shift-right immediate across the DW boundary
        begin_test(7);
        mem[0] = ins(3'b010, 1'b1, 200, 31);
        mem[1] = ins(3'b010, 1'b1, 200, 33);
        mem[2] = ins(3'b010, 1'b1, 200, 70);
        mem[3] = halt_at(3);
        mem[200] = 32'h8000_0000;
        push_wr(200, 32'd1);
        push_wr(200, 32'd2);
        push_wr(200, 32'd0);
        release_rst();
        run_halt("srl", 2000, 4);

        // Indirect copy, both modes
        begin_test(5);
        mem[0] = ins(3'b101, 1'b0, 331, 330);
        mem[1] = ins(3'b101, 1'b1, 332, 333);
        mem[2] = halt_at(2);
        mem[330] = 32'd100; mem[100] = 32'd6;
        mem[332] = 32'd200; mem[333] = 32'h0000_dead;
        push_wr(331, 32'd6);
        push_wr(200, 32'h0000_dead);
        release_rst();
        run_halt("cpi", 2000, 3);
        check_val("cpi_mem200", 64'(mem[200]), 64'h0000_dead);

        // Count-down loop 3 -> 0, exit branch, then self-branch halt
        begin_test(7);
        mem[0] = ins(3'b000, 1'b0, 400, 401);
        mem[1] = ins(3'b110, 1'b0, 402, 400);
        mem[2] = ins(3'b110, 1'b1, 1000, 0);
        mem[3] = halt_at(3);
        mem[400] = 32'd3; mem[401] = 32'hffff_ffff; mem[402] = 32'd3;
        push_wr(400, 32'd2);
        push_wr(400, 32'd1);
        push_wr(400, 32'd0);
        release_rst();
        run_halt("bzj", 4000, 9);

        // A write to the next instruction slot is seen by the following fetch
        begin_test(2);
        mem[0]   = ins(3'b100, 1'b0, 1, 500);
        mem[1]   = ins(3'b000, 1'b1, 501, 5);
        mem[500] = halt_at(1);
        push_wr(1, halt_at(1));
        release_rst();
        run_halt("selfmod", 1000, 2);
        check_val("selfmod_mem501", 64'(mem[501]), 64'd0);

        // Narrow build: reset while an RD_B read is pending, then refetch from 0
        s_rst = 1'b1; s_ack = 1'b0;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        n = 0;
        while (s_state != 3'd3 && n < 20) begin
            s_ack   = s_req;
            s_rdata = 16'h0005;
            @(posedge clk);
            #1;
            n++;
        end
        check_val("s_reach_rdb", 64'(s_state), 64'd3);
        s_ack = 1'b0;
        @(posedge clk);
        #1;
        check_val("s_rdb_req", 64'(s_req), 64'd1);
        check_val("s_rdb_addr", 64'(s_addr), 64'd5);
        s_rst = 1'b1; s_ack = 1'b1; s_rdata = 16'hbeef;
        @(posedge clk);
        #1;
        check_val("s_rst_req", 64'(s_req), 64'd0);
        check_val("s_rst_out", 64'({s_we, s_addr, s_wdata}), 64'd0);
        check_val("s_rst_retired", 64'(s_retired), 64'd0);
        check_val("s_rst_halted", 64'(s_halted), 64'd0);
        check_val("s_rst_state", 64'(s_state), 64'd0);
        s_ack = 1'b0; s_rst = 1'b0;
        #1;
        check_val("s_refetch", 64'({s_req, s_we, s_addr}), 64'({1'b1, 1'b0, 8'd0}));
        s_ack = 1'b1; s_rdata = 16'h0000;
        @(posedge clk);
        #1;
        check_val("s_decode", 64'(s_state), 64'd1);
        s_ack = 1'b0;

        check_val("hs_stable", 64'(stab_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
